hazard_sequencer: RTL and testbench

//  Pipeline sequencer for the 5-stage MIPS core. Sits beside the ID-stage Control decoder
//  and owns the PC/IF-ID write enables, IF/ID flush, ID/EX control-bubble select and

---
 rtl/hazard_sequencer.sv | 135 +++++++++++++
 tb/tb_hazard_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline sequencer for the 5-stage MIPS core: load-use stalls, branch/jump flushes,
// data-memory freezes, post-reset warm-up and halt/drain/resume, plus saturating counters.
module hazard_sequencer #(
   parameter int INIT_CYCLES  = 2,
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             halt_i,
   input  logic             mem_busy_i,
   input  logic             IDEX_MemRead_i,
   input  logic [4:0]       IDEX_RegRt_i,
   input  logic [4:0]       IFID_RegRs_i,
   input  logic [4:0]       IFID_RegRt_i,
   input  logic             IFID_UseRt_i,
   input  logic             Branch_i,
   input  logic             Jump_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             IFIDFlush_o,
   output logic             CtrlBubble_o,
   output logic             PipeEn_o,
   output logic             Halted_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_HALT  = 2'b11
   } state_t;

   localparam int TMR_MAX = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] TMR_INIT  = TMR_W'(INIT_CYCLES);
   localparam logic [TMR_W-1:0] TMR_DRAIN = TMR_W'(DRAIN_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             hz;
   logic             redirect;
   logic             stall_inc;
   logic             flush_inc;

   assign hz = IDEX_MemRead_i && (IDEX_RegRt_i != 5'd0) &&
               ((IDEX_RegRt_i == IFID_RegRs_i) ||
                (IFID_UseRt_i && (IDEX_RegRt_i == IFID_RegRt_i)));
   assign redirect = Branch_i | Jump_i;

   // NOTE: every signal written here gets a default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      PCWrite_o    = 1'b0;
      IFIDWrite_o  = 1'b0;
      IFIDFlush_o  = 1'b1;
      CtrlBubble_o = 1'b1;
      PipeEn_o     = 1'b1;
      Halted_o     = 1'b0;
      state_nxt    = state;
      timer_nxt    = timer;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;

      case (state)
         ST_INIT: begin
            if (timer == TMR_ONE) state_nxt = ST_RUN;
            else                  timer_nxt = timer - TMR_ONE;
         end

         ST_RUN: begin
            IFIDFlush_o  = 1'b0;
            CtrlBubble_o = 1'b0;
            if (mem_busy_i) begin
               PipeEn_o = 1'b0;
            end else if (hz) begin
               // ID is re-evaluated next cycle, so a pending redirect is ignored here
               CtrlBubble_o = 1'b1;
               stall_inc    = 1'b1;
            end else if (halt_i) begin
               PCWrite_o   = redirect;
               IFIDWrite_o = 1'b1;
               IFIDFlush_o = 1'b1;
               flush_inc   = redirect;
               state_nxt   = ST_DRAIN;
               timer_nxt   = TMR_DRAIN;
            end else if (redirect) begin
               PCWrite_o   = 1'b1;
               IFIDWrite_o = 1'b1;
               IFIDFlush_o = 1'b1;
               flush_inc   = 1'b1;
            end else begin
               PCWrite_o   = 1'b1;
               IFIDWrite_o = 1'b1;
            end
         end

         ST_DRAIN: begin
            if (mem_busy_i)            PipeEn_o  = 1'b0;
            else if (timer == TMR_ONE) state_nxt = ST_HALT;
            else                       timer_nxt = timer - TMR_ONE;
         end

         ST_HALT: begin
            Halted_o = 1'b1;
            if (!halt_i) state_nxt = ST_RUN;
         end

         default: state_nxt = ST_INIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of its neighbours.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= ST_INIT;
         timer      <= TMR_INIT;
         StallCnt_o <= '0;
         FlushCnt_o <= '0;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
         if (stall_inc && (StallCnt_o != CNT_MAX)) StallCnt_o <= StallCnt_o + CNT_ONE;
         if (flush_inc && (FlushCnt_o != CNT_MAX)) FlushCnt_o <= FlushCnt_o + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer; a second instance with 2-bit counters shares
// all inputs so counter saturation is reached in a handful of events.
module tb_hazard_sequencer;

   localparam logic [4:0] T_INIT    = 5'b00111;
   localparam logic [4:0] T_RUN     = 5'b11001;
   localparam logic [4:0] T_STALL   = 5'b00011;
   localparam logic [4:0] T_FLUSH   = 5'b11101;
   localparam logic [4:0] T_FREEZE  = 5'b00000;
   localparam logic [4:0] T_HALTACC = 5'b01101;
   localparam logic [4:0] T_DRAINBZ = 5'b00110;

   logic        clk, rst_i, halt_i, mem_busy_i, IDEX_MemRead_i, IFID_UseRt_i, Branch_i, Jump_i;
   logic [4:0]  IDEX_RegRt_i, IFID_RegRs_i, IFID_RegRt_i;
   logic        PCWrite_o, IFIDWrite_o, IFIDFlush_o, CtrlBubble_o, PipeEn_o, Halted_o;
   logic [15:0] StallCnt_o, FlushCnt_o;
   logic        s_pcw, s_ifw, s_iff, s_cb, s_pe, s_halted;
   logic [1:0]  s_stall, s_flush;
   logic [4:0]  tup;

   int tests = 0;
   int fails = 0;

   hazard_sequencer #(.INIT_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(16)) dut (
      .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i), .mem_busy_i(mem_busy_i),
      .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RegRt_i(IDEX_RegRt_i),
      .IFID_RegRs_i(IFID_RegRs_i), .IFID_RegRt_i(IFID_RegRt_i), .IFID_UseRt_i(IFID_UseRt_i),
      .Branch_i(Branch_i), .Jump_i(Jump_i),
      .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFIDFlush_o(IFIDFlush_o),
      .CtrlBubble_o(CtrlBubble_o), .PipeEn_o(PipeEn_o), .Halted_o(Halted_o),
      .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
   );

   hazard_sequencer #(.INIT_CYCLES(2), .DRAIN_CYCLES(3), .CNT_W(2)) dut_sat (
      .clk_i(clk), .rst_i(rst_i), .halt_i(halt_i), .mem_busy_i(mem_busy_i),
      .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RegRt_i(IDEX_RegRt_i),
      .IFID_RegRs_i(IFID_RegRs_i), .IFID_RegRt_i(IFID_RegRt_i), .IFID_UseRt_i(IFID_UseRt_i),
      .Branch_i(Branch_i), .Jump_i(Jump_i),
      .PCWrite_o(s_pcw), .IFIDWrite_o(s_ifw), .IFIDFlush_o(s_iff),
      .CtrlBubble_o(s_cb), .PipeEn_o(s_pe), .Halted_o(s_halted),
      .StallCnt_o(s_stall), .FlushCnt_o(s_flush)
   );

   assign tup = {PCWrite_o, IFIDWrite_o, IFIDFlush_o, CtrlBubble_o, PipeEn_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // apply one input vector, then let the combinational outputs settle
   task automatic drv(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic br,
                      input logic jp, input logic hl, input logic bz);
      IDEX_MemRead_i = mr;
      IDEX_RegRt_i   = ert;
      IFID_RegRs_i   = rs;
      IFID_RegRt_i   = rt;
      IFID_UseRt_i   = urt;
      Branch_i       = br;
      Jump_i         = jp;
      halt_i         = hl;
      mem_busy_i     = bz;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_tuple", 32'(tup), 32'(T_INIT));
      check("rst_halted", 32'(Halted_o), 0);
      check("rst_stall", 32'(StallCnt_o), 0);
      check("rst_flush", 32'(FlushCnt_o), 0);
      tick();
      tick();

      // T1: two INIT cycles after release, then RUN
      rst_i = 1'b1;
      #1;
      check("init_c1", 32'(tup), 32'(T_INIT));
      tick();
      check("init_c2", 32'(tup), 32'(T_INIT));
      tick();
      check("run_first", 32'(tup), 32'(T_RUN));

      // T2: load-use on rs, rt==0 exclusion, rt-path with and without UseRt
      drv(1, 2, 2, 0, 0, 0, 0, 0, 0);
      check("hz_rs", 32'(tup), 32'(T_STALL));
      tick();
      check("stall_cnt1", 32'(StallCnt_o), 1);
      drv(1, 0, 0, 0, 1, 0, 0, 0, 0);
      check("hz_rt_zero", 32'(tup), 32'(T_RUN));
      tick();
      drv(1, 5, 3, 5, 1, 0, 0, 0, 0);
      check("hz_rt", 32'(tup), 32'(T_STALL));
      tick();
      check("stall_cnt2", 32'(StallCnt_o), 2);
      drv(1, 5, 3, 5, 0, 0, 0, 0, 0);
      check("hz_rt_unused", 32'(tup), 32'(T_RUN));
      tick();
      check("stall_cnt2_hold", 32'(StallCnt_o), 2);

      // T3: hazard beats branch; branch then jump flush
      drv(1, 2, 2, 0, 0, 1, 0, 0, 0);
      check("hz_over_br", 32'(tup), 32'(T_STALL));
      tick();
      check("stall_cnt3", 32'(StallCnt_o), 3);
      check("flush_cnt0", 32'(FlushCnt_o), 0);
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
      check("br_flush", 32'(tup), 32'(T_FLUSH));
      tick();
      check("flush_cnt1", 32'(FlushCnt_o), 1);
      drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("jmp_flush", 32'(tup), 32'(T_FLUSH));
      tick();
      check("flush_cnt2", 32'(FlushCnt_o), 2);
      check("sat_stall3", 32'(s_stall), 3);

      // T4: halt accept, 3 drain cycles, halt, resume
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("halt_accept", 32'(tup), 32'(T_HALTACC));
      check("halt_acc_h0", 32'(Halted_o), 0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("drain%0d_tuple", i), 32'(tup), 32'(T_INIT));
         check($sformatf("drain%0d_halted", i), 32'(Halted_o), 0);
         tick();
      end
      check("halted", 32'(Halted_o), 1);
      check("halt_tuple", 32'(tup), 32'(T_INIT));
      tick();
      check("halted_hold", 32'(Halted_o), 1);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("halted_last", 32'(Halted_o), 1);
      tick();
      check("resume_tuple", 32'(tup), 32'(T_RUN));
      check("resume_h0", 32'(Halted_o), 0);

      // halt is not accepted while a stall is inserted
      drv(1, 2, 2, 0, 0, 0, 0, 1, 0);
      check("hz_over_halt", 32'(tup), 32'(T_STALL));
      tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("still_run", 32'(tup), 32'(T_RUN));
      check("stall_cnt4", 32'(StallCnt_o), 4);
      check("sat_stall_hold", 32'(s_stall), 3);

      // T5: freeze in RUN (overrides hazard), then freeze mid-drain
      for (int i = 0; i < 4; i++) begin
         drv(1, 2, 2, 0, 0, 0, 0, 1, 1);
         check($sformatf("freeze%0d", i), 32'(tup), 32'(T_FREEZE));
         tick();
      end
      check("stall_cnt_frz", 32'(StallCnt_o), 4);
      drv(0, 0, 0, 0, 0, 1, 0, 1, 0);
      check("halt_br_accept", 32'(tup), 32'(T_FLUSH));
      tick();
      check("flush_cnt3", 32'(FlushCnt_o), 3);
      check("sat_flush3", 32'(s_flush), 3);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("drainb_c1", 32'(tup), 32'(T_INIT));
      tick();
      for (int i = 0; i < 4; i++) begin
         drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
         check($sformatf("drain_busy%0d", i), 32'(tup), 32'(T_DRAINBZ));
         check($sformatf("drain_busy%0d_h", i), 32'(Halted_o), 0);
         tick();
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("drainb_c2", 32'(tup), 32'(T_INIT));
      check("drainb_c2_h", 32'(Halted_o), 0);
      tick();
      check("drainb_c3_h", 32'(Halted_o), 0);
      tick();
      check("halted_late", 32'(Halted_o), 1);
      tick();
      check("resume2", 32'(tup), 32'(T_RUN));

      // T6: flush saturation in the narrow instance, then reset during DRAIN
      drv(0, 0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      check("flush_cnt4", 32'(FlushCnt_o), 4);
      check("sat_flush_hold", 32'(s_flush), 3);
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
      tick();
      check("pre_rst_drain", 32'(tup), 32'(T_INIT));
      rst_i = 1'b0;
      #1;
      check("mid_rst_tuple", 32'(tup), 32'(T_INIT));
      check("mid_rst_stall", 32'(StallCnt_o), 0);
      check("mid_rst_flush", 32'(FlushCnt_o), 0);
      check("mid_rst_halted", 32'(Halted_o), 0);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      rst_i = 1'b1;
      #1;
      check("rerst_c1", 32'(tup), 32'(T_INIT));
      tick();
      check("rerst_c2", 32'(tup), 32'(T_INIT));
      tick();
      check("rerst_run", 32'(tup), 32'(T_RUN));
      check("rerst_h0", 32'(Halted_o), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
